moore_pattern_checker: RTL
==========================

# moore_pattern_checker

Receive-side counterpart to the team's Moore serial pattern generators. It consumes a serial bit stream (`din`/`din_valid`), acquires frame alignment on a fixed PAT_LEN-bit pattern, declares lock after LOCK_COUNT consecutive good frames, and tracks loss of lock. It also counts frame errors. It sits directly at the far end of a generator link as a link-integrity monitor.

## Interface
- PATTERN, default 4'b1011: expected frame, MSB transmitted first.
- PAT_LEN, default 4: frame length in bits, ≥2.
- LOCK_COUNT, default 3: consecutive matching frames, counting the acquiring one, required to reach lock; ≥1.
- LOSS_COUNT, default 2: consecutive mismatching frames while locked that drop lock; ≥1.
- ERR_W, default 8: error counter width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  `din` is accepted on this rising edge.
- clear_err  in  1  synchronous clear of `err_count`.
- locked  out  1  high in LOCKED and LOST.
- frame_ok  out  1  one-cycle pulse after any frame-boundary match.
- err_count  out  ERR_W  saturating frame-mismatch count.
- state_o  out  3  current state encoding, for debug.

## Operation
- Window: `sr <= {sr[PAT_LEN-2:0], din}` on each valid bit, so the newest bit is the LSB. A fill counter saturates at PAT_LEN.
- `hit` is true when the next-window value equals PATTERN and the fill is complete, counting the current bit. All decisions use the window that includes the bit accepted on that edge.
- `phase` counts valid bits modulo PAT_LEN. A frame boundary is the valid bit with `phase == PAT_LEN-1`.
- FSM states are IDLE, HUNT, CONFIRM, LOCKED and LOST. State changes only on valid bits.
  - IDLE: the first valid bit is shifted in and the FSM goes to HUNT.
  - HUNT: evaluated on every valid bit. On `hit`, `phase` is set to 0 and `good` to 1. If LOCK_COUNT==1 the FSM goes to LOCKED; otherwise it goes to CONFIRM.
  - CONFIRM: evaluated at boundaries only.
    - On `hit`, `good` increments. When `good` reaches LOCK_COUNT the FSM goes to LOCKED.
    - On a miss, the FSM goes to HUNT and `good` is set to 0.
  - LOCKED: evaluated at boundaries only.
    - On `hit`, the FSM stays in LOCKED.
    - On a miss, `miss` is set to 1 and `err_count` increments. If LOSS_COUNT==1 the FSM goes to HUNT; otherwise it goes to LOST.
  - LOST: evaluated at boundaries only.
    - On `hit`, the FSM goes to LOCKED and `miss` is set to 0.
    - On a miss, `miss` and `err_count` increment. When `miss` reaches LOSS_COUNT the FSM goes to HUNT.
- `err_count` increments only on misses in LOCKED or LOST.
  - It saturates at 2^ERR_W-1.
  - `clear_err` takes priority over an increment in the same cycle; the result is 0.
- `frame_ok` is registered. It is 1 in the cycle after any `hit` that HUNT acts on, and after any boundary `hit`. Otherwise it is 0.

## Timing
- Reset values:
  - State is IDLE, `state_o` = 0.
  - `locked`, `frame_ok` and `err_count` are 0.
  - `sr`, the fill counter, `phase`, `good` and `miss` are 0.
- Reset asserted mid-operation produces these reset values at the next edge, whatever the state.
- All outputs are registered. Output latency is 1 cycle from the edge that accepts the deciding bit.
- When `din_valid` is 0, no internal state changes and `frame_ok` is 0. Gaps between valid bits are transparent.
- Simultaneous `rst` and `din_valid`: reset wins and the bit is dropped.

## Structure
- Shared package `pattern_pkg`:
  - the state enum, with encoding IDLE=0, HUNT=1, CONFIRM=2, LOCKED=3, LOST=4;
  - the default PATTERN and PAT_LEN constants, so generator and checker agree.
- Sub-module `pattern_window` contains the shift register, the fill counter and the combinational `hit`.
- The top module contains the FSM, the `phase`, `good` and `miss` counters, and the output registers.

## Test plan
All scenarios use the defaults: PATTERN=1011, PAT_LEN=4, LOCK_COUNT=3, LOSS_COUNT=2.
1. Reset, then 1011 repeated with `din_valid` held high.
   - `frame_ok` pulses after bits 4, 8 and 12.
   - `locked` = 1 in the cycle after bit 12; `state_o` = 3.
2. From lock, send one corrupt frame 1111, then 1011.
   - After the bad boundary: `locked` stays 1, `state_o` = 4, `err_count` = 1.
   - After the good frame: `state_o` = 3.
3. From lock, send two frames of 0000.
   - `err_count` = 2.
   - `locked` goes to 0 after the 8th bad bit; `state_o` = 1.
4. Same stream as scenario 1 with random `din_valid`=0 gaps of 1 to 5 cycles.
   - Identical output sequence when counted in valid bits.
5. Saturation and clear, with ERR_W=2.
   - Alternate bad and good frames after lock, 5 bad frames in total: `err_count` = 3 and `locked` stays 1.
   - Assert `clear_err` on the cycle of a bad boundary: `err_count` = 0.
6. Reset mid-CONFIRM, after 6 bits of 101110.
   - All outputs are 0 and `state_o` = 0 on the next edge.
   - A subsequent clean stream locks only after 12 valid bits.

Source files
------------

// File: rtl/pattern_pkg.sv
// Types and defaults shared by the serial pattern generators and the checker,
// so both ends of a link agree on the frame and the state encoding.
package pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_LOST    = 3'd4
    } state_t;

    localparam int unsigned DEFAULT_PAT_LEN = 4;
    localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_window.sv
// Receive window: shift register of the most recent PAT_LEN bits plus a fill
// counter; hit_c reports a full-window match including the bit arriving now.
module pattern_window #(
    parameter int unsigned         PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic hit_c
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] sr;
    logic [PAT_LEN-1:0] sr_nxt;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_nxt;

    // Look-ahead window so decisions see the bit accepted on this edge.
    always_comb begin
        sr_nxt   = PAT_LEN'({sr, din});
        fill_nxt = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);
        hit_c    = din_valid && (sr_nxt == PATTERN) && (fill_nxt == FILL_W'(PAT_LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            fill <= '0;
        end else if (din_valid) begin
            sr   <= sr_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/moore_pattern_checker.sv
// Link-integrity monitor: acquires frame alignment on a fixed serial pattern,
// declares lock after consecutive good frames and counts errors while locked.
module moore_pattern_checker
    import pattern_pkg::*;
#(
    parameter int unsigned        PAT_LEN    = DEFAULT_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN    = PAT_LEN'(DEFAULT_PATTERN),
    parameter int unsigned        LOCK_COUNT = 3,
    parameter int unsigned        LOSS_COUNT = 2,
    parameter int unsigned        ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_err,
    output logic             locked,
    output logic             frame_ok,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       state_o
);

    localparam int unsigned PH_W = $clog2(PAT_LEN);
    localparam int unsigned GD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MS_W = $clog2(LOSS_COUNT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   phase, phase_nxt;
    logic [GD_W-1:0]   good, good_nxt, good_inc;
    logic [MS_W-1:0]   miss, miss_nxt, miss_inc;
    logic [ERR_W-1:0]  err_nxt;
    logic              frame_ok_nxt;
    logic              locked_nxt;
    logic              err_inc;
    logic              boundary;
    logic              hit;

    pattern_window #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .hit_c     (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase     <= '0;
            good      <= '0;
            miss      <= '0;
            err_count <= '0;
            frame_ok  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            good      <= good_nxt;
            miss      <= miss_nxt;
            err_count <= err_nxt;
            frame_ok  <= frame_ok_nxt;
            locked    <= locked_nxt;
        end
    end

    // Next-state: HUNT acts on every bit, the aligned states only at frame boundaries.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        good_nxt     = good;
        miss_nxt     = miss;
        frame_ok_nxt = 1'b0;
        err_inc      = 1'b0;
        boundary     = (phase == PH_W'(PAT_LEN - 1));
        good_inc     = good + GD_W'(1);
        miss_inc     = miss + MS_W'(1);

        if (din_valid) begin
            phase_nxt = boundary ? '0 : phase + PH_W'(1);
            case (state)
                ST_IDLE: state_nxt = ST_HUNT;
                ST_HUNT: begin
                    if (hit) begin
                        phase_nxt    = '0;
                        good_nxt     = GD_W'(1);
                        miss_nxt     = '0;
                        frame_ok_nxt = 1'b1;
                        state_nxt    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (boundary) begin
                        if (hit) begin
                            frame_ok_nxt = 1'b1;
                            good_nxt     = good_inc;
                            if (good_inc == GD_W'(LOCK_COUNT)) begin
                                state_nxt = ST_LOCKED;
                            end
                        end else begin
                            good_nxt  = '0;
                            state_nxt = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        if (hit) begin
                            frame_ok_nxt = 1'b1;
                        end else begin
                            err_inc   = 1'b1;
                            miss_nxt  = MS_W'(1);
                            state_nxt = (LOSS_COUNT == 1) ? ST_HUNT : ST_LOST;
                        end
                    end
                end
                ST_LOST: begin
                    if (boundary) begin
                        if (hit) begin
                            frame_ok_nxt = 1'b1;
                            miss_nxt     = '0;
                            state_nxt    = ST_LOCKED;
                        end else begin
                            err_inc  = 1'b1;
                            miss_nxt = miss_inc;
                            if (miss_inc == MS_W'(LOSS_COUNT)) begin
                                state_nxt = ST_HUNT;
                            end
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Clear wins over a same-cycle increment; the count saturates.
        err_nxt = err_count;
        if (clear_err) begin
            err_nxt = '0;
        end else if (err_inc && (err_count != ERR_MAX)) begin
            err_nxt = err_count + ERR_W'(1);
        end

        locked_nxt = (state_nxt == ST_LOCKED) || (state_nxt == ST_LOST);
    end

    assign state_o = state;

endmodule
